counter_scheduler: RTL and testbench

- Time-shares one Size-bit free-running up-counter (clock, sync active-high clear, count output) between NumReq requesters.
- Each requester asks for an interval of len counter ticks.
- The block arbitrates round-robin, clears the counter, watches count reach the latched target, then signals done to the winner.
- Sits between client logic and the counter instance; it is the only driver of the counter's clear input.

---
 rtl/counter_scheduler.sv | 152 +++++++++++++++
 tb/tb_counter_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin time-sharing of one free-running up-counter.
// A winner gets the counter cleared, owns it until count reaches its latched
// target, then receives a one-cycle done pulse. Dropping the request aborts.
module counter_scheduler #(
    parameter int unsigned Size   = 5,
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdW    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NumReq-1:0]      req,
    input  logic [NumReq*Size-1:0] len,
    output logic [NumReq-1:0]      grant,
    output logic [NumReq-1:0]      done,
    output logic                   busy,
    output logic [IdW-1:0]         active_id,
    output logic                   cnt_reset,
    input  logic [Size-1:0]        cnt_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [NumReq-1:0]   grant_q, grant_d;
    logic [NumReq-1:0]   done_q, done_d;
    logic                busy_q, busy_d;
    logic [IdW-1:0]      active_id_q, active_id_d;
    logic                cnt_reset_q, cnt_reset_d;
    logic [IdW-1:0]      ptr_q, ptr_d;
    logic [Size-1:0]     target_q, target_d;

    logic [Size-1:0]     len_arr [NumReq];
    logic                pick_valid;
    logic [IdW-1:0]      pick_id;
    logic [IdW-1:0]      next_ptr;

    // Unpack the flat len bus into per-requester targets
    for (genvar g = 0; g < NumReq; g++) begin : g_len
        assign len_arr[g] = len[g*Size +: Size];
    end

    // Round-robin pick: first set request at or after ptr, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            int unsigned idx;
            logic [IdW-1:0] cand;
            idx = 32'(ptr_q) + i;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            cand = IdW'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Pointer value used after the current owner finishes or aborts
    assign next_ptr = (active_id_q == IdW'(NumReq - 1)) ? '0 : active_id_q + 1'b1;

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        active_id_d = active_id_q;
        ptr_d       = ptr_q;
        target_d    = target_q;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d     = S_CLEAR;
                    grant_d     = NumReq'(1) << pick_id;
                    active_id_d = pick_id;
                    target_d    = len_arr[pick_id];
                end
            end
            S_CLEAR: begin
                if (!req[active_id_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Withdrawal takes precedence over a coincident match
                if (!req[active_id_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (cnt_count == target_q) begin
                    state_d = S_DONE;
                    done_d  = grant_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        cnt_reset_d = (state_d != S_RUN);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            cnt_reset_q <= 1'b1;
            ptr_q       <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            cnt_reset_q <= cnt_reset_d;
            ptr_q       <= ptr_d;
            target_q    <= target_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign cnt_reset = cnt_reset_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: external counter model, expected grant
// transactions queued by the stimulus and compared by a grant monitor.
module tb_counter_scheduler;

    localparam int unsigned Size   = 5;
    localparam int unsigned NumReq = 4;
    localparam int unsigned IdW    = 2;

    logic                   clock;
    logic                   reset;
    logic [NumReq-1:0]      req;
    logic [NumReq*Size-1:0] len;
    logic [NumReq-1:0]      grant;
    logic [NumReq-1:0]      done;
    logic                   busy;
    logic [IdW-1:0]         active_id;
    logic                   cnt_reset;
    logic [Size-1:0]        cnt_count;

    typedef struct {
        int id;
        int width;
        int has_done;
        int runs;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    counter_scheduler #(.Size(Size), .NumReq(NumReq), .IdW(IdW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .active_id (active_id),
        .cnt_reset (cnt_reset),
        .cnt_count (cnt_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Free-running counter with synchronous active-high clear
    always_ff @(posedge clock) begin
        if (cnt_reset) cnt_count <= '0;
        else           cnt_count <= cnt_count + 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input int width, input int has_done, input int runs, input int gap);
        exp_t e;
        e.id = id; e.width = width; e.has_done = has_done; e.runs = runs; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic set_len(input int i, input int v);
        len[i*Size +: Size] = Size'(v);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        req   = '0;
        #1;
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_active_id", 32'(active_id), 0);
        check_eq("rst_cnt_reset", 32'(cnt_reset), 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_done(input logic [NumReq-1:0] mask, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if ((done & mask) != '0) return;
        end
        check_eq("done_timeout", 32'(done & mask), 32'(mask));
    endtask

    task automatic wait_run_count(input int id, input int value, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (grant[id] && !cnt_reset && (32'(cnt_count) == value)) return;
        end
        check_eq("run_count_timeout", 32'(cnt_count), 32'(value));
    endtask

    // Grant monitor: measures each grant interval and scores it against the queue
    bit               in_grant = 1'b0;
    logic [NumReq-1:0] cur_grant;
    logic [NumReq-1:0] done_seen;
    int               cur_id, width, runs, done_w;
    int               gap = 0;

    always @(negedge clock) begin
        if (reset && grant != '0) begin
            if (!in_grant) begin
                in_grant  = 1'b1;
                cur_grant = grant;
                width     = 0;
                runs      = 0;
                done_seen = '0;
                done_w    = 0;
                cur_id    = 0;
                for (int i = 0; i < NumReq; i++) if (grant[i]) cur_id = i;
                check_eq("grant_onehot", 32'($countones(grant)), 1);
                if (sb.size() > 0 && sb[0].gap >= 0) check_eq("idle_gap", 32'(gap), 32'(sb[0].gap));
            end
            width++;
            check_eq("grant_stable", 32'(grant), 32'(cur_grant));
            check_eq("active_id", 32'(active_id), 32'(cur_id));
            if (!cnt_reset) begin
                check_eq("run_count", 32'(cnt_count), 32'(runs));
                runs++;
            end
            if (done != '0) begin
                done_seen = done;
                done_w    = width;
            end
        end else begin
            if (in_grant) begin
                in_grant = 1'b0;
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_grant", 32'(cur_grant), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("grant_id", 32'(cur_id), 32'(e.id));
                    check_eq("grant_width", 32'(width), 32'(e.width));
                    check_eq("run_cycles", 32'(runs), 32'(e.runs));
                    check_eq("done_value", 32'(done_seen), e.has_done != 0 ? (32'd1 << e.id) : 32'd0);
                    if (e.has_done != 0) check_eq("done_last_cycle", 32'(done_w), 32'(width));
                end
                gap = 0;
            end
            if (done != '0) check_eq("stray_done", 32'(done), 0);
            if (reset) gap++;
            else       gap = 0;
        end
        check_eq("busy", 32'(busy), 32'(grant != '0));
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        len   = '0;

        // 1: single request, len 3
        do_reset();
        set_len(0, 3);
        push_exp(0, 6, 1, 4, -1);
        @(negedge clock);
        req = 4'b0001;
        @(negedge clock);
        check_eq("t1_grant_latency", 32'(grant), 32'b0001);
        wait_done(4'b0001, 20);
        req = '0;
        @(negedge clock);
        check_eq("t1_grant_after", 32'(grant), 0);
        check_eq("t1_busy_after", 32'(busy), 0);

        // 2: zero-length interval
        do_reset();
        set_len(0, 0);
        push_exp(0, 3, 1, 1, -1);
        @(negedge clock);
        req = 4'b0001;
        wait_done(4'b0001, 20);
        req = '0;

        // 3: all requesting continuously, rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NumReq; i++) set_len(i, 2);
        push_exp(0, 5, 1, 3, -1);
        push_exp(1, 5, 1, 3, 1);
        push_exp(2, 5, 1, 3, 1);
        push_exp(3, 5, 1, 3, 1);
        push_exp(0, 5, 1, 3, 1);
        @(negedge clock);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) wait_done(4'b1111, 20);
        req = '0;

        // 4: withdrawal at count 4, pending requester 2 follows
        do_reset();
        set_len(1, 10);
        set_len(2, 1);
        push_exp(1, 6, 0, 5, -1);
        push_exp(2, 4, 1, 2, 1);
        @(negedge clock);
        req = 4'b0110;
        wait_run_count(1, 4, 20);
        req[1] = 1'b0;
        wait_done(4'b0100, 20);
        req = '0;

        // 5: len change during RUN is ignored
        do_reset();
        set_len(0, 7);
        push_exp(0, 10, 1, 8, -1);
        @(negedge clock);
        req = 4'b0001;
        wait_run_count(0, 2, 20);
        set_len(0, 1);
        wait_done(4'b0001, 20);
        req = '0;

        // 6: reset mid-interval, then index 0 wins over 1
        @(negedge clock);
        set_len(0, 5);
        push_exp(0, 4, 0, 3, -1);
        req = 4'b0001;
        wait_run_count(0, 2, 20);
        #1;
        reset = 1'b0;
        #1;
        check_eq("t6_grant_async", 32'(grant), 0);
        check_eq("t6_done_async", 32'(done), 0);
        check_eq("t6_busy_async", 32'(busy), 0);
        check_eq("t6_cnt_reset_async", 32'(cnt_reset), 1);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        set_len(0, 1);
        set_len(1, 1);
        push_exp(0, 4, 1, 2, -1);
        push_exp(1, 4, 1, 2, 1);
        req = 4'b0011;
        wait_done(4'b0001, 20);
        req = 4'b0010;
        wait_done(4'b0010, 20);
        req = '0;

        repeat (4) @(negedge clock);
        check_eq("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
